// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, state and width definitions shared by the alu_seq slice
package alu_pkg;

    localparam int OPW = 4;

    typedef enum logic [OPW-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_NOT   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_EQ    = 4'd7,
        OP_SLTU  = 4'd8,
        OP_SLL   = 4'd9,
        OP_SRL   = 4'd10,
        OP_SRA   = 4'd11,
        OP_MUL   = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result handshake bundle between operand stage, ALU and write-back
interface alu_seq_if #(parameter int WIDTH = 8);

    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         a;
    logic [WIDTH-1:0]         b;
    logic [alu_pkg::OPW-1:0]  func;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out;
    logic                     zero;
    logic                     overflow;
    logic                     carry_out;

    modport master (
        output in_valid, a, b, func, out_ready,
        input  in_ready, out_valid, out, zero, overflow, carry_out
    );

    modport slave (
        input  in_valid, a, b, func, out_ready,
        output in_ready, out_valid, out, zero, overflow, carry_out
    );

endinterface

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - shared combinational adder/subtractor with carry and signed overflow
module alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] bEff;

    // Subtraction is a + ~b + 1, so carry = 1 means no borrow.
    always_comb begin
        bEff         = sub ? ~b : b;
        {carry, sum} = {1'b0, a} + {1'b0, bEff} + {{WIDTH{1'b0}}, sub};
        ovf          = (a[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered results and an iterative shift-add multiplier
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_MUL  = ST_MUL;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]         state;
    alu_op_e            op;
    logic               asSub;
    logic [WIDTH-1:0]   asSum;
    logic               asCarry;
    logic               asOvf;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   res;
    logic               resOvf;
    logic               resCarry;
    logic               accept;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               mulFlush;

    logic [WIDTH-1:0]   outR;
    logic               zeroR;
    logic               ovfR;
    logic               carryR;

    assign op     = alu_op_e'(bus.func);
    assign asSub  = (op != OP_ADD);
    assign sh     = bus.b[SHW-1:0];
    assign accept = bus.in_valid & bus.in_ready;

    // One adder serves ADD, SUB and all three compares.
    alu_addsub #(.WIDTH(WIDTH)) uAddSub (
        .a     (bus.a),
        .b     (bus.b),
        .sub   (asSub),
        .sum   (asSum),
        .carry (asCarry),
        .ovf   (asOvf)
    );

    always_comb begin
        res      = '0;
        resOvf   = 1'b0;
        resCarry = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res      = asSum;
                resOvf   = asOvf;
                resCarry = asCarry;
            end
            OP_NOT:  res = ~bus.a;
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_XOR:  res = bus.a ^ bus.b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, asSum[WIDTH-1] ^ asOvf};
            OP_EQ:   res = {{(WIDTH-1){1'b0}}, asSum == '0};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, ~asCarry};
            OP_SLL:  res = bus.a << sh;
            OP_SRL:  res = bus.a >> sh;
            OP_SRA:  res = WIDTH'($signed(bus.a) >>> sh);
            default: res = '0;
        endcase
    end

    assign bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state == S_DONE);
    assign bus.out       = outR;
    assign bus.zero      = zeroR;
    assign bus.overflow  = ovfR;
    assign bus.carry_out = carryR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            mulFlush <= 1'b0;
            outR     <= '0;
            zeroR    <= 1'b1;
            ovfR     <= 1'b0;
            carryR   <= 1'b0;
        end else begin
            case (state)
                S_MUL: begin
                    // The final cycle after the last bit only writes the finished product.
                    if (mulFlush) begin
                        state  <= S_DONE;
                        outR   <= acc[WIDTH-1:0];
                        zeroR  <= (acc[WIDTH-1:0] == '0);
                        ovfR   <= 1'b0;
                        carryR <= |acc[2*WIDTH-1:WIDTH];
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (cnt == SHW'(WIDTH-1)) mulFlush <= 1'b1;
                        else                      cnt      <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state    <= S_MUL;
                            acc      <= '0;
                            cnt      <= '0;
                            mulFlush <= 1'b0;
                            mcand    <= {{WIDTH{1'b0}}, bus.a};
                            mplier   <= bus.b;
                        end else begin
                            state  <= S_DONE;
                            outR   <= res;
                            zeroR  <= (res == '0);
                            ovfR   <= resOvf;
                            carryR <= resCarry;
                        end
                    end else if ((state == S_DONE) && bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with directed corner cases and random traffic
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [7:0] out;
        logic       zero;
        logic       ovf;
        logic       cy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t sb[$];
    int   nChecks = 0;
    int   nFail = 0;
    int   popCount = 0;
    int   cyc = 0;
    int   acceptCyc = 0;
    logic rdyMode = 1'b0;
    logic readyForce = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(logic [7:0] o, logic z, logic v, logic c);
        exp_t e;
        e.out = o; e.zero = z; e.ovf = v; e.cy = c;
        return e;
    endfunction

    // Reference computed with integer arithmetic on the operand values.
    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic [3:0] f);
        exp_t e;
        int sa = $signed(a);
        int sb2 = $signed(b);
        int ua = a;
        int ub = b;
        int k = ub % 8;
        int r;
        e.out = 8'h00; e.ovf = 1'b0; e.cy = 1'b0;
        case (f)
            4'd0: begin
                r = ua + ub; e.out = r[7:0]; e.cy = (r > 255);
                e.ovf = (sa + sb2 > 127) || (sa + sb2 < -128);
            end
            4'd1: begin
                e.out = 8'(ua - ub); e.cy = (ua >= ub);
                e.ovf = (sa - sb2 > 127) || (sa - sb2 < -128);
            end
            4'd2:  e.out = ~a;
            4'd3:  e.out = a & b;
            4'd4:  e.out = a | b;
            4'd5:  e.out = a ^ b;
            4'd6:  e.out = (sa < sb2) ? 8'd1 : 8'd0;
            4'd7:  e.out = (ua == ub) ? 8'd1 : 8'd0;
            4'd8:  e.out = (ua < ub) ? 8'd1 : 8'd0;
            4'd9:  e.out = 8'(ua << k);
            4'd10: e.out = 8'(ua >> k);
            4'd11: e.out = 8'(sa >>> k);
            4'd12: begin
                r = ua * ub; e.out = r[7:0]; e.cy = ((r >> 8) != 0);
            end
            default: e.out = 8'h00;
        endcase
        e.zero = (e.out == 8'h00);
        return e;
    endfunction

    task automatic issue(logic [7:0] a, logic [7:0] b, logic [3:0] f, exp_t e);
        logic ok = 1'b0;
        bus.a = a; bus.b = b; bus.func = f; bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(e);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nChecks++; nFail++;
            $display("FAIL accept_timeout: got no accept in 200 cycles, expected accept");
        end
        @(posedge clk);
        #1;
        acceptCyc = cyc;
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.func = 4'($urandom);
    endtask

    task automatic drain();
        logic ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            nChecks++; nFail++;
            $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chkReset(string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(1));
        chk({tag, "_out"},       32'(bus.out),       32'(0));
        chk({tag, "_zero"},      32'(bus.zero),      32'(1));
        chk({tag, "_overflow"},  32'(bus.overflow),  32'(0));
        chk({tag, "_carry_out"}, 32'(bus.carry_out), 32'(0));
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rdyMode ? ($urandom_range(0, 9) < 7) : readyForce;
        end
    end

    // Monitor: pops an expectation whenever a result is taken, and checks holds while stalled.
    initial begin
        exp_t e;
        exp_t saved;
        logic heldValid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (heldValid) begin
                    chk("hold_out",  32'(bus.out),       32'(saved.out));
                    chk("hold_zero", 32'(bus.zero),      32'(saved.zero));
                    chk("hold_ovf",  32'(bus.overflow),  32'(saved.ovf));
                    chk("hold_cy",   32'(bus.carry_out), 32'(saved.cy));
                end
                chk("in_ready_follows_out_ready", 32'(bus.in_ready), 32'(bus.out_ready));
                if (bus.out_ready) begin
                    heldValid = 1'b0;
                    if (sb.size() == 0) begin
                        nChecks++; nFail++;
                        $display("FAIL unexpected_result: got out=%0h, expected no result", bus.out);
                    end else begin
                        e = sb.pop_front();
                        chk("out",       32'(bus.out),       32'(e.out));
                        chk("zero",      32'(bus.zero),      32'(e.zero));
                        chk("overflow",  32'(bus.overflow),  32'(e.ovf));
                        chk("carry_out", 32'(bus.carry_out), 32'(e.cy));
                        popCount++;
                    end
                end else begin
                    saved.out = bus.out; saved.zero = bus.zero;
                    saved.ovf = bus.overflow; saved.cy = bus.carry_out;
                    heldValid = 1'b1;
                end
            end else begin
                heldValid = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got time limit, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowCnt;
        int k;
        int start;
        int c1;
        int c2;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] rf;

        bus.in_valid = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.func = 4'h0;
        rst_n = 1'b0;
        @(negedge clk);
        chkReset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(8'h7F, 8'h01, OP_ADD,  mk(8'h80, 1'b0, 1'b1, 1'b0));
        issue(8'h00, 8'h01, OP_SUB,  mk(8'hFF, 1'b0, 1'b0, 1'b0));
        issue(8'h05, 8'h05, OP_SUB,  mk(8'h00, 1'b1, 1'b0, 1'b1));
        issue(8'h80, 8'h01, OP_SLT,  mk(8'h01, 1'b0, 1'b0, 1'b0));
        issue(8'h80, 8'h01, OP_SLTU, mk(8'h00, 1'b1, 1'b0, 1'b0));
        issue(8'h3C, 8'h3C, OP_EQ,   mk(8'h01, 1'b0, 1'b0, 1'b0));
        issue(8'h90, 8'h0A, OP_SRA,  mk(8'hE4, 1'b0, 1'b0, 1'b0));
        issue(8'h55, 8'hAA, OP_RSV14, mk(8'h00, 1'b1, 1'b0, 1'b0));
        drain();

        issue(8'h10, 8'h20, OP_MUL, mk(8'h00, 1'b1, 1'b0, 1'b1));
        lowCnt = 0;
        k = 0;
        while (k < 30) begin
            @(negedge clk);
            k++;
            if (bus.out_valid) break;
            if (!bus.in_ready) lowCnt++;
        end
        chk("mul_in_ready_low_cycles", 32'(lowCnt), 32'(9));
        chk("mul_latency_edges", 32'(k - 1), 32'(9));
        drain();

        start = popCount;
        issue(8'h11, 8'h22, OP_ADD, model(8'h11, 8'h22, 4'd0));
        c1 = acceptCyc;
        issue(8'hF0, 8'h20, OP_ADD, model(8'hF0, 8'h20, 4'd0));
        c2 = acceptCyc;
        chk("b2b_accept_gap1", 32'(c2 - c1), 32'(1));
        issue(8'h40, 8'h40, OP_ADD, model(8'h40, 8'h40, 4'd0));
        chk("b2b_accept_gap2", 32'(acceptCyc - c2), 32'(1));
        @(negedge clk);
        #1;
        chk("b2b_results", 32'(popCount - start), 32'(3));
        drain();

        readyForce = 1'b0;
        @(posedge clk);
        #1;
        issue(8'h12, 8'h34, OP_XOR, model(8'h12, 8'h34, 4'd5));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(bus.out_valid), 32'(1));
            chk("stall_in_ready",  32'(bus.in_ready),  32'(0));
        end
        @(posedge clk);
        #1;
        readyForce = 1'b1;
        drain();

        issue(8'hC3, 8'h5A, OP_MUL, model(8'hC3, 8'h5A, 4'd12));
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chkReset("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = popCount;
        repeat (12) @(negedge clk);
        chk("abort_no_result", 32'(popCount - start), 32'(0));
        @(posedge clk);
        #1;
        issue(8'h21, 8'h05, OP_ADD, mk(8'h26, 1'b0, 1'b0, 1'b0));
        drain();
        chk("post_reset_add_done", 32'(popCount - start), 32'(1));

        rdyMode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            ra = 8'($urandom);
            rb = 8'($urandom);
            rf = ($urandom_range(0, 7) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
            issue(ra, rb, rf, model(ra, rb, rf));
        end
        rdyMode = 1'b0;
        readyForce = 1'b1;
        drain();

        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
